addsub_serial: RTL and testbench

Parametrised, multi-cycle adder/subtractor for the datapath. It computes `i1 + i2` or `i1 - i2` over `WIDTH` bits, processing `DIGIT` bits per clock from the LSB upward. It has a start/ready/done handshake and registered result flags. It replaces the fixed 32-bit combinational subtractor wherever area matters more than latency, and adds an add mode and status flags the combinational unit lacks.

---
 rtl/addsub_serial.sv | 76 +++++++
 tb/tb_addsub_serial.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial adder/subtractor with start/ready/done handshake and result flags
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a, b, sh, res;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] sum;
  logic c, last, acc, msb_cin;
  assign sum = {1'b0, a[DIGIT-1:0]} + {1'b0, b[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
  assign res = WIDTH'({sum[DIGIT-1:0], sh} >> DIGIT);
  assign msb_cin = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
  assign last = cnt == CW'(N - 1);
  assign ready = state == IDLE || state == DONE;
  assign done = state == DONE;
  assign acc = start && ready;
  // next state: accept from IDLE/DONE, leave RUN on the last digit, DONE lasts one cycle
  always_comb begin
    state_nx = state;
    state_nx = acc ? RUN : (state == RUN && last) ? DONE : (state == DONE) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // digit datapath; visible outputs only load on the last digit so partial sums never show
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      sh <= '0;
      c <= 1'b0;
      cnt <= '0;
      out <= '0;
      carry <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
    end else if (acc) begin
      a <= i1;
      b <= sub ? ~i2 : i2;
      c <= sub;
      cnt <= '0;
    end else if (state == RUN) begin
      a <= a >> DIGIT;
      b <= b >> DIGIT;
      c <= sum[DIGIT];
      sh <= res;
      cnt <= cnt + 1'b1;
      if (last) begin
        out <= res;
        carry <= sum[DIGIT];
        overflow <= msb_cin ^ sum[DIGIT];
        zero <= res == '0;
        negative <= sum[DIGIT-1];
      end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed vector table plus handshake, reset and 8-bit parameter sweep checks
module tb_addsub_serial;
  logic clk = 0, rst_n = 0, start = 0, sub = 0;
  logic [31:0] i1 = 0, i2 = 0, out;
  logic ready, done, carry, overflow, zero, negative;
  logic start8 = 0, sub8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [7:0] o8[3];
  logic r8[3], d8[3], c8[3], v8[3], z8[3], n8[3];
  int n_cmp = 0, n_bad = 0, cyc = 0, e0 = 0;

  typedef struct {
    logic s;
    logic [31:0] x, y, o;
    logic [3:0] f;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_serial dut (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .i1(i1), .i2(i2),
    .ready(ready), .done(done), .out(out), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative));
  addsub_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .i1(a8), .i2(b8),
    .ready(r8[0]), .done(d8[0]), .out(o8[0]), .carry(c8[0]), .overflow(v8[0]), .zero(z8[0]), .negative(n8[0]));
  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .i1(a8), .i2(b8),
    .ready(r8[1]), .done(d8[1]), .out(o8[1]), .carry(c8[1]), .overflow(v8[1]), .zero(z8[1]), .negative(n8[1]));
  addsub_serial #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .i1(a8), .i2(b8),
    .ready(r8[2]), .done(d8[2]), .out(o8[2]), .carry(c8[2]), .overflow(v8[2]), .zero(z8[2]), .negative(n8[2]));

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [35:0] res();
    return {out, carry, overflow, zero, negative};
  endfunction

  function automatic logic [11:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] bb;
    logic [8:0] t;
    logic v;
    bb = s ? ~y : y;
    t = {1'b0, x} + {1'b0, bb} + {8'b0, s};
    v = (x[7] == bb[7]) && (t[7] != x[7]);
    return {t[7:0], t[8], v, t[7:0] == 8'd0, t[7]};
  endfunction

  task automatic accept(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    sub = s;
    i1 = x;
    i2 = y;
    start = 1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 0;
  endtask

  task automatic wait_done(output int lat);
    int k = 0;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    lat = done ? cyc - e0 : -1;
  endtask

  task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y);
    int lat[3];
    int exp_lat[3];
    logic [11:0] e;
    exp_lat = '{8, 4, 1};
    for (int j = 0; j < 3; j++) lat[j] = 0;
    @(negedge clk);
    sub8 = s;
    a8 = x;
    b8 = y;
    start8 = 1;
    @(posedge clk);
    #1;
    start8 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) if (d8[j] && lat[j] == 0) lat[j] = k;
    end
    e = ref8(s, x, y);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("w8_lat_n%0d", exp_lat[j]), lat[j], exp_lat[j]);
      chk($sformatf("w8_res_n%0d s%0d %h %h", exp_lat[j], s, x, y), {o8[j], c8[j], v8[j], z8[j], n8[j]}, e);
    end
  endtask

  initial begin
    int lat, d1, d2;
    logic seen;
    logic [7:0] cv[8];
    tbl[0] = '{1'b1, 32'd5, 32'd3, 32'd2, 4'b1000};
    tbl[1] = '{1'b1, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b0001};
    tbl[2] = '{1'b1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b1100};
    tbl[3] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1010};
    tbl[4] = '{1'b0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0101};
    tbl[5] = '{1'b1, 32'd0, 32'd0, 32'd0, 4'b1010};
    tbl[6] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 4'b0001};
    cv = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    #2;
    chk("reset_ready", ready, 1);
    chk("reset_outs", {done, res()}, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      accept(tbl[i].s, tbl[i].x, tbl[i].y);
      chk($sformatf("busy%0d", i), ready, 0);
      wait_done(lat);
      chk($sformatf("lat%0d", i), lat, 8);
      chk($sformatf("res%0d", i), res(), {tbl[i].o, tbl[i].f});
      @(posedge clk);
      #1;
      chk($sformatf("done_width%0d", i), done, 0);
      chk($sformatf("ready_after%0d", i), ready, 1);
    end
    accept(1, 32'd5, 32'd3);
    @(negedge clk);
    start = 1;
    sub = 0;
    i1 = 100;
    i2 = 1;
    @(negedge clk);
    start = 0;
    i1 = 77;
    wait_done(lat);
    chk("ignore_lat", lat, 8);
    chk("ignore_res", res(), {32'd2, 4'b1000});
    d1 = cyc;
    accept(0, 32'h7FFFFFFF, 32'd1);
    wait_done(lat);
    d2 = cyc;
    chk("b2b_gap", d2 - d1, 9);
    chk("b2b_res", res(), {32'h80000000, 4'b0101});
    accept(0, 32'h1111, 32'h2222);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_outs", {done, res()}, 0);
    seen = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("rst_no_done", seen, 0);
    accept(0, 32'd10, 32'd20);
    wait_done(lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_res", res(), {32'd30, 4'b0000});
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++) op8(s[0], cv[x], cv[y]);
    for (int k = 0; k < 100; k++) op8(1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
